// File: rtl/range_adj_pkg.sv
// Shared constants for the range adjust sequencer: FSM encodings, size defaults
// and the decimal power table used for digit lengths and segment bounds.
package range_adj_pkg;

  localparam int DEF_W      = 40;
  localparam int MAX_DIGITS = 12;
  localparam int DEF_LW     = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t CNT_LO  = 3'd1;
  localparam state_t CNT_HI  = 3'd2;
  localparam state_t ADJ_MIN = 3'd3;
  localparam state_t ADJ_MAX = 3'd4;
  localparam state_t SEG     = 3'd5;
  localparam state_t EMIT    = 3'd6;

  // POW10[k] for k = 0..MAX_DIGITS; indices outside the table give 0.
  function automatic logic [63:0] pow10(input logic [7:0] k);
    logic [63:0] p;
    case (k)
      8'd0:    p = 64'd1;
      8'd1:    p = 64'd10;
      8'd2:    p = 64'd100;
      8'd3:    p = 64'd1000;
      8'd4:    p = 64'd10000;
      8'd5:    p = 64'd100000;
      8'd6:    p = 64'd1000000;
      8'd7:    p = 64'd10000000;
      8'd8:    p = 64'd100000000;
      8'd9:    p = 64'd1000000000;
      8'd10:   p = 64'd10000000000;
      8'd11:   p = 64'd100000000000;
      8'd12:   p = 64'd1000000000000;
      default: p = 64'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/range_adj_ctrl_digit_len_cnt.sv
// Iterative decimal digit counter: one comparison against a growing power of
// ten per cycle, so a value of L digits reports done in its L-th cycle.
module digit_len_cnt #(
  parameter int W          = 40,
  parameter int LW         = 4,
  parameter int MAX_DIGITS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  value,
  output logic          done,
  output logic [LW-1:0] len
);

  logic [W-1:0]  val_r;
  logic [W-1:0]  pow_r;
  logic [LW-1:0] len_r;
  logic          active_r;
  logic          step_s;

  assign step_s = (val_r >= pow_r) && (len_r < LW'(MAX_DIGITS));
  assign done   = active_r && !step_s;
  assign len    = len_r;

  // Load on start, then multiply the power by ten until the value falls below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r    <= {W{1'b0}};
      pow_r    <= {W{1'b0}};
      len_r    <= {LW{1'b0}};
      active_r <= 1'b0;
    end else if (start) begin
      val_r    <= value;
      pow_r    <= W'(4'd10);
      len_r    <= LW'(1'b1);
      active_r <= 1'b1;
    end else if (active_r && step_s) begin
      pow_r    <= (pow_r << 3) + (pow_r << 1);
      len_r    <= len_r + LW'(1'b1);
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/range_adj_ctrl_min_max_adj.sv
// Combinational minMaxAdj: moves an odd-length bound onto the nearest even
// digit length (up for a minimum, down for a maximum).
module min_max_adj #(
  parameter int W  = 40,
  parameter int LW = 4
) (
  input  logic          en,
  input  logic          sel,
  input  logic [W-1:0]  value,
  input  logic [LW-1:0] len,
  output logic [W-1:0]  adj_value,
  output logic [LW-1:0] adj_len
);

  import range_adj_pkg::*;

  // Even lengths and a disabled block pass through untouched.
  always_comb begin
    adj_value = value;
    adj_len   = len;
    if (en && len[0]) begin
      if (!sel) begin
        adj_value = W'(pow10(8'(len)));
        adj_len   = len + LW'(1'b1);
      end else begin
        adj_value = W'(pow10(8'(len) - 8'd1)) - W'(1'b1);
        adj_len   = len - LW'(1'b1);
      end
    end else begin
      adj_value = value;
      adj_len   = len;
    end
  end

endmodule

// File: rtl/range_adj_ctrl.sv
// Range adjust sequencer: counts digits of both bounds, evens them out through
// one shared minMaxAdj, then emits one beat per even digit-length segment.
module range_adj_ctrl #(
  parameter int W          = range_adj_pkg::DEF_W,
  parameter int MAX_DIGITS = range_adj_pkg::MAX_DIGITS,
  parameter int LW         = range_adj_pkg::DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_lo,
  input  logic [W-1:0]  in_hi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_lo,
  output logic [W-1:0]  out_hi,
  output logic [LW-1:0] out_half,
  output logic          out_empty,
  output logic          out_last,
  output logic          busy
);

  import range_adj_pkg::*;

  state_t        state_r, state_s;
  logic [W-1:0]  lo_r, lo_s, hi_r, hi_s;
  logic          inv_r, inv_s;
  logic [LW-1:0] len_lo_r, len_lo_s, len_hi_r, len_hi_s;
  logic [W-1:0]  adj_lo_r, adj_lo_s, adj_hi_r, adj_hi_s;
  logic [LW-1:0] adj_len_lo_r, adj_len_lo_s, adj_len_hi_r, adj_len_hi_s;
  logic [LW-1:0] seg_len_r, seg_len_s;
  logic [W-1:0]  out_lo_r, out_lo_s, out_hi_r, out_hi_s;
  logic [LW-1:0] out_half_r, out_half_s;
  logic          out_empty_r, out_empty_s, out_last_r, out_last_s;
  logic          out_valid_r, out_valid_s, in_ready_r, in_ready_s, busy_r, busy_s;

  logic          cnt_start_s, cnt_done_s;
  logic [W-1:0]  cnt_value_s;
  logic [LW-1:0] cnt_len_s;
  logic          mma_sel_s;
  logic [W-1:0]  mma_value_s, mma_adj_value_s;
  logic [LW-1:0] mma_len_s, mma_adj_len_s;
  logic [W-1:0]  seg_floor_s, seg_ceil_s;
  logic [LW:0]   seg_len_p2_s;

  digit_len_cnt #(.W(W), .LW(LW), .MAX_DIGITS(MAX_DIGITS)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cnt_start_s),
    .value (cnt_value_s),
    .done  (cnt_done_s),
    .len   (cnt_len_s)
  );

  min_max_adj #(.W(W), .LW(LW)) u_mma (
    .en        (1'b1),
    .sel       (mma_sel_s),
    .value     (mma_value_s),
    .len       (mma_len_s),
    .adj_value (mma_adj_value_s),
    .adj_len   (mma_adj_len_s)
  );

  // Next-state, shared-resource steering and beat construction.
  always_comb begin
    state_s      = state_r;
    lo_s         = lo_r;
    hi_s         = hi_r;
    inv_s        = inv_r;
    len_lo_s     = len_lo_r;
    len_hi_s     = len_hi_r;
    adj_lo_s     = adj_lo_r;
    adj_hi_s     = adj_hi_r;
    adj_len_lo_s = adj_len_lo_r;
    adj_len_hi_s = adj_len_hi_r;
    seg_len_s    = seg_len_r;
    out_lo_s     = out_lo_r;
    out_hi_s     = out_hi_r;
    out_half_s   = out_half_r;
    out_empty_s  = out_empty_r;
    out_last_s   = out_last_r;
    out_valid_s  = out_valid_r;
    cnt_start_s  = 1'b0;
    cnt_value_s  = hi_r;
    mma_sel_s    = 1'b0;
    mma_value_s  = lo_r;
    mma_len_s    = len_lo_r;
    seg_floor_s  = W'(pow10(8'(seg_len_r) - 8'd1));
    seg_ceil_s   = W'(pow10(8'(seg_len_r))) - W'(1'b1);
    seg_len_p2_s = {1'b0, seg_len_r} + {{(LW-1){1'b0}}, 2'd2};

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          lo_s = in_lo;
          hi_s = in_hi;
          if (in_lo > in_hi) begin
            inv_s   = 1'b1;
            state_s = SEG;
          end else begin
            inv_s       = 1'b0;
            cnt_start_s = 1'b1;
            cnt_value_s = in_lo;
            state_s     = CNT_LO;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CNT_LO: begin
        // The counter is restarted on hi in the same cycle lo finishes.
        if (cnt_done_s) begin
          len_lo_s    = cnt_len_s;
          cnt_start_s = 1'b1;
          cnt_value_s = hi_r;
          state_s     = CNT_HI;
        end else begin
          state_s = CNT_LO;
        end
      end
      CNT_HI: begin
        if (cnt_done_s) begin
          len_hi_s = cnt_len_s;
          state_s  = ADJ_MIN;
        end else begin
          state_s = CNT_HI;
        end
      end
      ADJ_MIN: begin
        mma_sel_s    = 1'b0;
        mma_value_s  = lo_r;
        mma_len_s    = len_lo_r;
        adj_lo_s     = mma_adj_value_s;
        adj_len_lo_s = mma_adj_len_s;
        seg_len_s    = mma_adj_len_s;
        state_s      = ADJ_MAX;
      end
      ADJ_MAX: begin
        mma_sel_s    = 1'b1;
        mma_value_s  = hi_r;
        mma_len_s    = len_hi_r;
        adj_hi_s     = mma_adj_value_s;
        adj_len_hi_s = mma_adj_len_s;
        state_s      = SEG;
      end
      SEG: begin
        out_valid_s = 1'b1;
        state_s     = EMIT;
        if (inv_r || (adj_lo_r > adj_hi_r) || (adj_len_lo_r > adj_len_hi_r)) begin
          out_lo_s    = {W{1'b0}};
          out_hi_s    = {W{1'b0}};
          out_half_s  = {LW{1'b0}};
          out_empty_s = 1'b1;
          out_last_s  = 1'b1;
        end else begin
          out_lo_s    = (adj_lo_r > seg_floor_s) ? adj_lo_r : seg_floor_s;
          out_hi_s    = (adj_hi_r < seg_ceil_s) ? adj_hi_r : seg_ceil_s;
          out_half_s  = {1'b0, seg_len_r[LW-1:1]};
          out_empty_s = 1'b0;
          out_last_s  = seg_len_p2_s > {1'b0, adj_len_hi_r};
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (out_last_r) begin
            state_s = IDLE;
          end else begin
            seg_len_s = seg_len_r + LW'(2'd2);
            state_s   = SEG;
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase

    in_ready_s = (state_s == IDLE);
    busy_s     = (state_s != IDLE);
  end

  // State and registered outputs; reset drops any range in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lo_r         <= {W{1'b0}};
      hi_r         <= {W{1'b0}};
      inv_r        <= 1'b0;
      len_lo_r     <= {LW{1'b0}};
      len_hi_r     <= {LW{1'b0}};
      adj_lo_r     <= {W{1'b0}};
      adj_hi_r     <= {W{1'b0}};
      adj_len_lo_r <= {LW{1'b0}};
      adj_len_hi_r <= {LW{1'b0}};
      seg_len_r    <= {LW{1'b0}};
      out_lo_r     <= {W{1'b0}};
      out_hi_r     <= {W{1'b0}};
      out_half_r   <= {LW{1'b0}};
      out_empty_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      lo_r         <= lo_s;
      hi_r         <= hi_s;
      inv_r        <= inv_s;
      len_lo_r     <= len_lo_s;
      len_hi_r     <= len_hi_s;
      adj_lo_r     <= adj_lo_s;
      adj_hi_r     <= adj_hi_s;
      adj_len_lo_r <= adj_len_lo_s;
      adj_len_hi_r <= adj_len_hi_s;
      seg_len_r    <= seg_len_s;
      out_lo_r     <= out_lo_s;
      out_hi_r     <= out_hi_s;
      out_half_r   <= out_half_s;
      out_empty_r  <= out_empty_s;
      out_last_r   <= out_last_s;
      out_valid_r  <= out_valid_s;
      in_ready_r   <= in_ready_s;
      busy_r       <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_lo    = out_lo_r;
  assign out_hi    = out_hi_r;
  assign out_half  = out_half_r;
  assign out_empty = out_empty_r;
  assign out_last  = out_last_r;

endmodule
